// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for the in-order MIPS pipeline. It sits
// beside the ID stage and tracks every instruction that has left decode in a
// DEPTH-slot shift table (slot 0 = EX, slot DEPTH-1 = WB). From the table and
// the instruction currently in ID it derives:
//   - per-operand forwarding selects (0 = register file, k+1 = slot k),
//   - a load-use stall that holds PC and IF/ID while a bubble enters slot 0,
//   - a registered flush that squashes IF/ID for BR_SHADOW cycles after a
//     taken branch resolves in slot 0.
//
// Optional build macro: HAZ_PERF_CNT_EN adds saturating 32-bit stall/flush
// cycle counters (stall_cycles, flush_cycles).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   id_valid            valid instruction in ID
//   id_rs, id_rt        source registers; id_rs_used/id_rt_used qualify them
//   id_dst, id_wen      destination register and its write enable
//   id_is_load          ID instruction is a load
//   ex_branch_taken     branch in slot 0 resolved taken this cycle
//   issue               ID instruction enters slot 0 at this edge
//   stall               hold PC and IF/ID, bubble into slot 0
//   flush               squash IF/ID contents (registered)
//   fwd_rs_sel          rs operand source select
//   fwd_rt_sel          rt operand source select
//   inflight            number of valid slots
//   stall_cycles        (HAZ_PERF_CNT_EN) cycles with stall=1
//   flush_cycles        (HAZ_PERF_CNT_EN) cycles with flush=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 3,
  parameter int ALU_RDY   = 0,
  parameter int LOAD_RDY  = 1,
  parameter int BR_SHADOW = 2,
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              issue,
  output logic              stall,
  output logic              flush,
  output logic [SW-1:0]     fwd_rs_sel,
  output logic [SW-1:0]     fwd_rt_sel,
  output logic [SW-1:0]     inflight
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  // Counter wide enough to hold BR_SHADOW-1 even when BR_SHADOW is 1.
  localparam int FCW = $clog2(BR_SHADOW + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SHADOW = 1'b1
  } fstate_e;

  // In-flight table.
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             wen_q,   wen_d;
  logic [DEPTH-1:0]             load_q,  load_d;
  logic [DEPTH-1:0][REG_AW-1:0] dst_q,   dst_d;

  // Flush FSM.
  fstate_e        state_q, state_d;
  logic [FCW-1:0] fcnt_q,  fcnt_d;
  logic           flush_q, flush_d;

  logic           haz_rs_s, haz_rt_s;
  logic [SW-1:0]  sel_rs_s, sel_rt_s;

  // Searches the table for the youngest producer of src. Returns {hazard, sel}.
  // A producer that is not yet far enough down the pipe to forward from
  // (ALU_RDY / LOAD_RDY) is a hazard; r0 never matches.
  function automatic logic [SW:0] lookup(
    input logic [REG_AW-1:0]             src,
    input logic                          used,
    input logic                          vld_id,
    input logic [DEPTH-1:0]              vld,
    input logic [DEPTH-1:0]              wen,
    input logic [DEPTH-1:0]              ld,
    input logic [DEPTH-1:0][REG_AW-1:0]  dst
  );
    logic          hit;
    logic          haz;
    logic [SW-1:0] sel;
    hit = 1'b0;
    haz = 1'b0;
    sel = '0;
    if (used && vld_id && (src != '0)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && vld[k] && wen[k] && (dst[k] == src)) begin
          hit = 1'b1;
          if (k >= (ld[k] ? LOAD_RDY : ALU_RDY)) begin
            sel = SW'(k + 1);
          end else begin
            haz = 1'b1;
          end
        end
      end
    end
    return {haz, sel};
  endfunction

  // Operand lookup for both sources.
  always_comb begin
    {haz_rs_s, sel_rs_s} = lookup(id_rs, id_rs_used, id_valid,
                                  valid_q, wen_q, load_q, dst_q);
    {haz_rt_s, sel_rt_s} = lookup(id_rt, id_rt_used, id_valid,
                                  valid_q, wen_q, load_q, dst_q);
  end

  // Stall/issue decisions; an active flush overrides any hazard.
  always_comb begin
    stall      = (haz_rs_s | haz_rt_s) & ~flush_q;
    issue      = id_valid & ~stall & ~flush_q;
    fwd_rs_sel = sel_rs_s;
    fwd_rt_sel = sel_rt_s;
    flush      = flush_q;
  end

  // Next table contents: shift down one slot, bubble into slot 0 unless issuing.
  always_comb begin
    valid_d[0] = issue;
    wen_d[0]   = issue & id_wen;
    load_d[0]  = issue & id_is_load;
    dst_d[0]   = id_dst;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      wen_d[k]   = wen_q[k-1];
      load_d[k]  = load_q[k-1];
      dst_d[k]   = dst_q[k-1];
    end
  end

  // Table registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      wen_q   <= '0;
      load_q  <= '0;
      dst_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      load_q  <= load_d;
      dst_q   <= dst_d;
    end
  end

  // Occupancy count.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < DEPTH; k++) begin
      inflight = inflight + SW'(valid_q[k]);
    end
  end

  // Flush FSM state register, including the registered flush output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      flush_q <= flush_d;
    end
  end

  // Flush FSM next state. Taken branches during the shadow are ignored since
  // the instruction that produced them is already being squashed.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_branch_taken) begin
          state_d = ST_SHADOW;
          fcnt_d  = FCW'(BR_SHADOW - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHADOW: begin
        if (fcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Flush FSM output decode; flush is registered, so decode the next state.
  always_comb begin
    case (state_d)
      ST_SHADOW: flush_d = 1'b1;
      ST_IDLE:   flush_d = 1'b0;
      default:   flush_d = 1'b0;
    endcase
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_q && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for pipe_hazard_ctrl with default parameters
// (REG_AW=5, DEPTH=3, ALU_RDY=0, LOAD_RDY=1, BR_SHADOW=2).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge unless a step needs to observe an asynchronous effect.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_rs_used, id_rt_used, id_wen, id_is_load;
  logic       ex_branch_taken;
  logic       issue, stall, flush;
  logic [1:0] fwd_rs_sel, fwd_rt_sel, inflight;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int total;
  int bad;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .id_dst          (id_dst),
    .id_wen          (id_wen),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .issue           (issue),
    .stall           (stall),
    .flush           (flush),
    .fwd_rs_sel      (fwd_rs_sel),
    .fwd_rt_sel      (fwd_rt_sel),
    .inflight        (inflight)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu,
                        input logic [4:0] dst, input logic wen, input logic ld);
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_dst     = dst;
    id_wen     = wen;
    id_is_load = ld;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) adv();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset state
    samp();
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_issue", {31'd0, issue}, 32'd0);
    chk("rst_inflight", {30'd0, inflight}, 32'd0);
    adv();
    reset = 1'b0;
    adv();

    // Back-to-back ALU dependency: add r8<-r9,r10 ; sub r11<-r8,r9
    set_id(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd8, 1'b1, 1'b0);
    samp();
    chk("alu_first_issue", {31'd0, issue}, 32'd1);
    chk("alu_first_rs", {30'd0, fwd_rs_sel}, 32'd0);
    adv();
    set_id(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);
    samp();
    chk("alu_dep_stall", {31'd0, stall}, 32'd0);
    chk("alu_dep_rs", {30'd0, fwd_rs_sel}, 32'd1);
    chk("alu_dep_rt", {30'd0, fwd_rt_sel}, 32'd0);
    chk("alu_dep_inflight", {30'd0, inflight}, 32'd1);
    adv();
    idle(3);
    samp();
    chk("drain_inflight", {30'd0, inflight}, 32'd0);

    // Load-use: lw r12 ; add r13<-r12,r12
    adv();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    adv();
    set_id(1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0);
    samp();
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_issue", {31'd0, issue}, 32'd0);
    adv();
    samp();
    chk("lu_stall_released", {31'd0, stall}, 32'd0);
    chk("lu_issue_after", {31'd0, issue}, 32'd1);
    chk("lu_rs_sel", {30'd0, fwd_rs_sel}, 32'd2);
    chk("lu_rt_sel", {30'd0, fwd_rt_sel}, 32'd2);
    chk("lu_bubble_inflight", {30'd0, inflight}, 32'd1);
    adv();
    idle(3);

    // Unused operand never stalls: lw r5 ; rs=r5 unused, rt=r6 used
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    adv();
    set_id(1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
    samp();
    chk("unused_rs_stall", {31'd0, stall}, 32'd0);
    adv();
    idle(3);

    // Youngest match wins
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
    adv();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
    adv();
    set_id(1'b1, 5'd8, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
    samp();
    chk("young_rs_sel", {30'd0, fwd_rs_sel}, 32'd1);
    adv();
    idle(4);
    set_id(1'b1, 5'd8, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
    samp();
    chk("aged_rs_sel", {30'd0, fwd_rs_sel}, 32'd0);
    chk("aged_inflight", {30'd0, inflight}, 32'd0);
    chk("aged_stall", {31'd0, stall}, 32'd0);
    adv();
    idle(3);

    // r0 rule: lw r0 ; add r1<-r0,r0
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    adv();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    samp();
    chk("r0_stall", {31'd0, stall}, 32'd0);
    chk("r0_rs_sel", {30'd0, fwd_rs_sel}, 32'd0);
    chk("r0_rt_sel", {30'd0, fwd_rt_sel}, 32'd0);
    adv();
    idle(3);

    // Branch shadow: lw r20 issues with taken pulse; dependent add in ID
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1);
    ex_branch_taken = 1'b1;
    samp();
    chk("br_t0_flush", {31'd0, flush}, 32'd0);
    chk("br_t0_issue", {31'd0, issue}, 32'd1);
    adv();
    set_id(1'b1, 5'd20, 1'b1, 5'd20, 1'b1, 5'd21, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;   // second pulse inside shadow, must be ignored
    samp();
    chk("br_t1_flush", {31'd0, flush}, 32'd1);
    chk("br_t1_stall", {31'd0, stall}, 32'd0);
    chk("br_t1_issue", {31'd0, issue}, 32'd0);
    adv();
    ex_branch_taken = 1'b0;
    samp();
    chk("br_t2_flush", {31'd0, flush}, 32'd1);
    chk("br_t2_issue", {31'd0, issue}, 32'd0);
    adv();
    samp();
    chk("br_t3_flush", {31'd0, flush}, 32'd0);
    chk("br_t3_issue", {31'd0, issue}, 32'd1);
    chk("br_t3_rs_sel", {30'd0, fwd_rs_sel}, 32'd3);
    adv();
    idle(3);

    // Taken branch in the same cycle as a load-use stall
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    adv();
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    samp();
    chk("brst_stall", {31'd0, stall}, 32'd1);
    adv();
    ex_branch_taken = 1'b0;
    samp();
    chk("brst_flush", {31'd0, flush}, 32'd1);
    chk("brst_inflight", {30'd0, inflight}, 32'd1);
    idle(4);
    samp();
    chk("brst_flush_end", {31'd0, flush}, 32'd0);
    adv();

    // Reset mid-shadow with three valid slots
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    adv();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    adv();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    ex_branch_taken = 1'b1;
    adv();
    ex_branch_taken = 1'b0;
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    chk("pre_rst_inflight", {30'd0, inflight}, 32'd3);
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_flush", {31'd0, flush}, 32'd0);
    chk("async_rst_inflight", {30'd0, inflight}, 32'd0);
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("async_rst_stall_cnt", stall_cycles, 32'd0);
    chk("async_rst_flush_cnt", flush_cycles, 32'd0);
`endif
    adv();
    adv();
    reset = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
